// File: rtl/vec_mem_sequencer_if.sv
// Processor-side bundle for the vector memory sequencer: request, source lanes,
// data memory port and vector register file write port.
interface vec_mem_sequencer_if;
    logic        Start;
    logic        IsStore;
    logic [31:0] BaseAddr;
    logic [3:0]  VecIdx;
    logic [31:0] VecRd_0;
    logic [31:0] VecRd_1;
    logic [31:0] VecRd_2;
    logic [31:0] VecRd_3;
    logic [31:0] VecRd_4;
    logic [31:0] ReadData;
    logic [31:0] MemAddr;
    logic        MemWrite;
    logic [31:0] MemWData;
    logic        VecWrite;
    logic [3:0]  VecWAddr;
    logic [31:0] VecWD_0;
    logic [31:0] VecWD_1;
    logic [31:0] VecWD_2;
    logic [31:0] VecWD_3;
    logic [31:0] VecWD_4;
    logic        Busy;
    logic        Done;

    modport master (
        output Start, IsStore, BaseAddr, VecIdx,
        output VecRd_0, VecRd_1, VecRd_2, VecRd_3, VecRd_4, ReadData,
        input  MemAddr, MemWrite, MemWData, VecWrite, VecWAddr,
        input  VecWD_0, VecWD_1, VecWD_2, VecWD_3, VecWD_4, Busy, Done
    );

    modport slave (
        input  Start, IsStore, BaseAddr, VecIdx,
        input  VecRd_0, VecRd_1, VecRd_2, VecRd_3, VecRd_4, ReadData,
        output MemAddr, MemWrite, MemWData, VecWrite, VecWAddr,
        output VecWD_0, VecWD_1, VecWD_2, VecWD_3, VecWD_4, Busy, Done
    );
endinterface

// File: rtl/vec_mem_sequencer.sv
// Sequences a 5-lane vector load or store through a single-word data memory port,
// one lane per cycle, with a final register-file writeback for loads.
module vec_mem_sequencer #(
    parameter int STRIDE = 4
) (
    input logic               clk,
    input logic               reset,
    vec_mem_sequencer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, XFER, WB, DONE} state_t;

    state_t      state;
    logic [2:0]  lane;
    logic        is_store;
    logic [31:0] base;
    logic [3:0]  vec_idx;
    logic [31:0] lane_buf [0:4];

    logic [31:0] mem_addr;
    logic        mem_write;
    logic [31:0] mem_wdata;
    logic        vec_write;
    logic [3:0]  vec_waddr;
    logic        busy;
    logic        done;

    logic [2:0]  lane_nxt;
    logic [31:0] addr_nxt;
    logic [31:0] aligned_base;

    assign lane_nxt     = lane + 3'd1;
    assign addr_nxt     = base + 32'(lane_nxt) * 32'(STRIDE);
    assign aligned_base = bus.BaseAddr & ~32'h3;

    // Outputs are registered one step ahead: each transition loads the values
    // the destination state must present, so the memory port sees them for the
    // whole cycle the lane is active.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            lane      <= 3'd0;
            is_store  <= 1'b0;
            base      <= 32'd0;
            vec_idx   <= 4'd0;
            for (int i = 0; i < 5; i++) lane_buf[i] <= 32'd0;
            mem_addr  <= 32'd0;
            mem_write <= 1'b0;
            mem_wdata <= 32'd0;
            vec_write <= 1'b0;
            vec_waddr <= 4'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.Start) begin
                        state     <= XFER;
                        lane      <= 3'd0;
                        is_store  <= bus.IsStore;
                        base      <= aligned_base;
                        vec_idx   <= bus.VecIdx;
                        busy      <= 1'b1;
                        mem_addr  <= aligned_base;
                        mem_write <= bus.IsStore;
                        mem_wdata <= bus.IsStore ? bus.VecRd_0 : 32'd0;
                        if (bus.IsStore) begin
                            lane_buf[0] <= bus.VecRd_0;
                            lane_buf[1] <= bus.VecRd_1;
                            lane_buf[2] <= bus.VecRd_2;
                            lane_buf[3] <= bus.VecRd_3;
                            lane_buf[4] <= bus.VecRd_4;
                        end
                    end
                end
                XFER: begin
                    if (!is_store) lane_buf[lane] <= bus.ReadData;
                    if (lane == 3'd4) begin
                        lane      <= 3'd0;
                        mem_addr  <= 32'd0;
                        mem_write <= 1'b0;
                        mem_wdata <= 32'd0;
                        if (is_store) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state     <= WB;
                            vec_write <= 1'b1;
                            vec_waddr <= vec_idx;
                        end
                    end else begin
                        lane      <= lane_nxt;
                        mem_addr  <= addr_nxt;
                        mem_write <= is_store;
                        mem_wdata <= is_store ? lane_buf[lane_nxt] : 32'd0;
                    end
                end
                WB: begin
                    state     <= DONE;
                    vec_write <= 1'b0;
                    vec_waddr <= 4'd0;
                    done      <= 1'b1;
                end
                DONE: begin
                    // Clearing the buffer here keeps the write lanes at zero while idle.
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    for (int i = 0; i < 5; i++) lane_buf[i] <= 32'd0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.MemAddr  = mem_addr;
    assign bus.MemWrite = mem_write;
    assign bus.MemWData = mem_wdata;
    assign bus.VecWrite = vec_write;
    assign bus.VecWAddr = vec_waddr;
    assign bus.VecWD_0  = lane_buf[0];
    assign bus.VecWD_1  = lane_buf[1];
    assign bus.VecWD_2  = lane_buf[2];
    assign bus.VecWD_3  = lane_buf[3];
    assign bus.VecWD_4  = lane_buf[4];
    assign bus.Busy     = busy;
    assign bus.Done     = done;
endmodule

// File: tb/tb_vec_mem_sequencer.sv
// Directed bench for vec_mem_sequencer: a scoreboard of expected memory writes and
// register-file writebacks is filled at request time and drained by a monitor.
module tb_vec_mem_sequencer;
    localparam int STRIDE = 4;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    typedef struct packed {
        logic [3:0]       idx;
        logic [4:0][31:0] lanes;
    } vrf_t;

    logic clk;
    logic reset;
    vec_mem_sequencer_if bus ();

    wr_t  wr_q  [$];
    vrf_t vrf_q [$];
    int   checks;
    int   passes;
    int   write_count;
    int   done_count;

    vec_mem_sequencer #(.STRIDE(STRIDE)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    // Memory image: a known window at 0x200..0x210, address-derived data elsewhere.
    function automatic logic [31:0] data_at(input logic [31:0] a);
        if (a >= 32'h200 && a <= 32'h210) return 32'hA0 + ((a - 32'h200) >> 2);
        return ~a;
    endfunction

    assign bus.ReadData = data_at(bus.MemAddr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    endtask

    // Scoreboard drain: every memory write and every writeback must match the
    // oldest outstanding expectation.
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.MemWrite === 1'b1) begin
                write_count++;
                check_output("write_expected", 32'(wr_q.size() != 0), 32'd1);
                if (wr_q.size() != 0) begin
                    wr_t e;
                    e = wr_q.pop_front();
                    check_output("wr_addr", bus.MemAddr, e.addr);
                    check_output("wr_data", bus.MemWData, e.data);
                end
            end
            if (bus.VecWrite === 1'b1) begin
                check_output("vrf_expected", 32'(vrf_q.size() != 0), 32'd1);
                if (vrf_q.size() != 0) begin
                    vrf_t v;
                    v = vrf_q.pop_front();
                    check_output("vrf_idx", 32'(bus.VecWAddr), 32'(v.idx));
                    check_output("vrf_lane0", bus.VecWD_0, v.lanes[0]);
                    check_output("vrf_lane1", bus.VecWD_1, v.lanes[1]);
                    check_output("vrf_lane2", bus.VecWD_2, v.lanes[2]);
                    check_output("vrf_lane3", bus.VecWD_3, v.lanes[3]);
                    check_output("vrf_lane4", bus.VecWD_4, v.lanes[4]);
                end
            end
            if (bus.Done === 1'b1) done_count++;
        end
    end

    task automatic apply_stimulus(input logic store, input logic [31:0] base_addr,
                                  input logic [3:0] idx, input logic [31:0] seed);
        logic [31:0] aligned;
        vrf_t        v;
        aligned = base_addr & ~32'h3;
        bus.IsStore  = store;
        bus.BaseAddr = base_addr;
        bus.VecIdx   = idx;
        bus.VecRd_0  = seed;
        bus.VecRd_1  = seed + 32'd1;
        bus.VecRd_2  = seed + 32'd2;
        bus.VecRd_3  = seed + 32'd3;
        bus.VecRd_4  = seed + 32'd4;
        v.idx = idx;
        for (int k = 0; k < 5; k++) begin
            logic [31:0] a;
            a = aligned + 32'(STRIDE * k);
            v.lanes[k] = data_at(a);
            if (store) wr_q.push_back('{addr: a, data: seed + 32'(k)});
        end
        if (!store) vrf_q.push_back(v);
        bus.Start = 1'b1;
    endtask

    task automatic wait_done(input logic store, input logic [31:0] base_addr, input string tag);
        int          lat;
        int          busy_cycles;
        logic [31:0] aligned;
        aligned     = base_addr & ~32'h3;
        lat         = 0;
        busy_cycles = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (bus.Busy === 1'b1) busy_cycles++;
            if (k <= 5) begin
                check_output({tag, "_addr"}, bus.MemAddr, aligned + 32'(STRIDE * (k - 1)));
                check_output({tag, "_memwrite"}, 32'(bus.MemWrite), 32'(store));
            end
            if (bus.Done === 1'b1) begin
                lat = k;
                break;
            end
        end
        check_output({tag, "_done_latency"}, 32'(lat), store ? 32'd6 : 32'd7);
        check_output({tag, "_busy_cycles"}, 32'(busy_cycles), store ? 32'd6 : 32'd7);
        @(negedge clk);
        check_output({tag, "_idle_busy"}, 32'(bus.Busy), 32'd0);
        check_output({tag, "_idle_addr"}, bus.MemAddr, 32'd0);
        check_output({tag, "_idle_vecwd0"}, bus.VecWD_0, 32'd0);
    endtask

    task automatic run_op(input logic store, input logic [31:0] base_addr,
                          input logic [3:0] idx, input logic [31:0] seed, input string tag);
        apply_stimulus(store, base_addr, idx, seed);
        @(posedge clk);
        #1 bus.Start = 1'b0;
        wait_done(store, base_addr, tag);
    endtask

    initial begin
        int w0;
        int d0;
        checks = 0; passes = 0; write_count = 0; done_count = 0;
        reset = 1'b1;
        bus.Start = 1'b0; bus.IsStore = 1'b0; bus.BaseAddr = 32'd0; bus.VecIdx = 4'd0;
        bus.VecRd_0 = 32'd0; bus.VecRd_1 = 32'd0; bus.VecRd_2 = 32'd0;
        bus.VecRd_3 = 32'd0; bus.VecRd_4 = 32'd0;
        #2;
        check_output("rst_busy", 32'(bus.Busy), 32'd0);
        check_output("rst_done", 32'(bus.Done), 32'd0);
        check_output("rst_memwrite", 32'(bus.MemWrite), 32'd0);
        check_output("rst_vecwrite", 32'(bus.VecWrite), 32'd0);
        check_output("rst_addr", bus.MemAddr, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        $display("[TB] store of 1..5 at 0x100");
        run_op(1'b1, 32'h100, 4'd1, 32'd1, "store_basic");

        $display("[TB] misaligned load at 0x203 into v3");
        run_op(1'b0, 32'h203, 4'd3, 32'hDEAD0000, "load_misaligned");

        $display("[TB] load wrapping past the top of memory");
        run_op(1'b0, 32'hFFFF_FFF8, 4'd7, 32'd0, "load_wrap");

        $display("[TB] start pulse during a store transfer");
        w0 = write_count;
        d0 = done_count;
        apply_stimulus(1'b1, 32'h300, 4'd2, 32'h55);
        @(posedge clk);
        #1 bus.Start = 1'b0;
        @(negedge clk);
        bus.Start = 1'b1;
        @(negedge clk);
        bus.Start = 1'b0;
        for (int k = 0; k < 12; k++) @(negedge clk);
        check_output("ignore_writes", 32'(write_count - w0), 32'd5);
        check_output("ignore_dones", 32'(done_count - d0), 32'd1);
        check_output("ignore_idle", 32'(bus.Busy), 32'd0);
        check_output("ignore_queue", 32'(wr_q.size()), 32'd0);

        $display("[TB] reset during lane 2 of a store");
        apply_stimulus(1'b1, 32'h400, 4'd4, 32'h10);
        @(posedge clk);
        #1 bus.Start = 1'b0;
        repeat (3) @(negedge clk);
        #1 reset = 1'b1;
        #1;
        check_output("abort_memwrite", 32'(bus.MemWrite), 32'd0);
        check_output("abort_busy", 32'(bus.Busy), 32'd0);
        check_output("abort_addr", bus.MemAddr, 32'd0);
        check_output("abort_vecwd0", bus.VecWD_0, 32'd0);
        wr_q.delete();
        w0 = write_count;
        d0 = done_count;
        repeat (3) @(negedge clk);
        check_output("abort_no_writes", 32'(write_count - w0), 32'd0);
        check_output("abort_no_done", 32'(done_count - d0), 32'd0);
        reset = 1'b0;
        run_op(1'b1, 32'h500, 4'd5, 32'h20, "after_reset");

        $display("[TB] start held high across two stores");
        apply_stimulus(1'b1, 32'h600, 4'd6, 32'h100);
        @(posedge clk);
        #1 apply_stimulus(1'b1, 32'h700, 4'd8, 32'h200);
        for (int k = 1; k <= 13; k++) begin
            @(negedge clk);
            check_output($sformatf("b2b_busy_c%0d", k), 32'(bus.Busy), (k == 7) ? 32'd0 : 32'd1);
            check_output($sformatf("b2b_done_c%0d", k), 32'(bus.Done),
                         (k == 6 || k == 13) ? 32'd1 : 32'd0);
            if (k == 7) begin
                @(posedge clk);
                #1 bus.Start = 1'b0;
            end
        end
        @(negedge clk);
        check_output("b2b_idle", 32'(bus.Busy), 32'd0);

        repeat (2) @(negedge clk);
        check_output("final_wr_queue", 32'(wr_q.size()), 32'd0);
        check_output("final_vrf_queue", 32'(vrf_q.size()), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] simulation time limit reached");
    end
endmodule
